mcs4_phase_gen: RTL and testbench
=================================

// Module: mcs4_phase_gen
// PURPOSE
// - Parametrised successor to the fixed 2-phase clockgen used by the MCS-4 system top.
// - Derives non-overlapping clk1/clk2 from sysclk with ns-specified timing, tracks the
//   8-state 4004 machine cycle (A1 A2 A3 M1 M2 X1 X2 X3), supplies a reference sync and
//   a stretched power-on-clear, and supports halting at machine-cycle boundaries.
// - Sits at system top; drives clk1_pad/clk2_pad/poc_pad of i4004, i4001, i4002.
// PARAMETERS
// - SYSCLK_TCY  50    sysclk period, ns
// - TCY_NS      1350  clk1/clk2 period, ns       -> TCY = ceil(TCY_NS/SYSCLK_TCY) ticks (27)
// - PW_NS       400   clk1 and clk2 high width, ns -> PW = ceil(PW_NS/SYSCLK_TCY) (8)
// - GAP12_NS    400   clk1 fall to clk2 rise, ns   -> G = ceil(GAP12_NS/SYSCLK_TCY) (8)
// - POC_CYCLES  4     machine cycles poc_out stays high after reset release (0 allowed)
// - Elaboration error unless TCY >= 2*PW + G + 1 (guarantees clk2->clk1 gap >= 1 tick).
// PORTS
// - sysclk        in   1  system clock, all logic on rising edge
// - reset         in   1  synchronous, active-high
// - clk_en        in   1  run enable, sampled only at end of X3
// - step          in   1  single-machine-cycle request (only with MCS4_STEP_EN)
// - clk1          out  1  phase-1 clock, registered
// - clk2          out  1  phase-2 clock, registered
// - phase_strobe  out  1  one-sysclk pulse on tick 0 of every clock period
// - cyc_phase     out  3  machine-cycle state, 0=A1 ... 7=X3
// - sync_ref      out  1  high for whole X3 clock period (reference sync)
// - poc_out       out  1  power-on clear to chips, active-high
// BEHAVIOUR
// - Reset values: tick=TCY-1, cyc_phase=7, clk1=0, clk2=0, phase_strobe=0, sync_ref=0,
//   poc_out=1, poc count=0, state HALT-pending-run. Reset mid-operation aborts instantly.
// - tick counts 0..TCY-1; all outputs registered from the next tick, so on the edge tick
//   becomes v: clk1 = (v < PW), clk2 = (PW+G <= v < 2*PW+G), phase_strobe = (v == 0).
// - First edge after reset release (clk_en=1): tick=0, cyc_phase=0 (A1), clk1=1.
// - cyc_phase increments (mod 8) on each tick wrap to 0; sync_ref = running && phase==7.
// - States: RUN, HALT. At tick TCY-1 of X3: clk_en=1 -> stay/enter RUN (next A1 tick 0);
//   clk_en=0 -> HALT. clk_en changes mid machine cycle have no effect until X3 end.
// - HALT: tick frozen at TCY-1, cyc_phase=7, clk1=clk2=phase_strobe=sync_ref=0;
//   leaves on first edge with clk_en=1, going to A1 tick 0 on that edge.
// - poc_out: counter ++ on each X3->A1 wrap while poc_out=1; clears on the edge where
//   count reaches POC_CYCLES (that A1 tick-0 edge). POC_CYCLES=0: clears on first edge
//   after release. HALT time does not count. Counter width $clog2(POC_CYCLES+1), min 1.
// - clk1 and clk2 never high in the same sysclk cycle under any input sequence.
// CONFIGURATION
// - MCS4_STEP_EN defined: step port exists. In HALT, step=1 (one sysclk) runs exactly
//   one machine cycle A1..X3 then re-HALTs unless clk_en=1 at X3 end. step ignored in
//   RUN; step held high while halted = one cycle per X3 boundary; step+clk_en = run.
// - Not defined: no step port; HALT exits only via clk_en.
// TESTING
// - Defaults, reset 5 cyc then release, clk_en=1 -> clk1 high 8 sysclk (ticks 0-7), clk2
//   high ticks 16-23, period 27, never overlapping; first clk1=1 on first edge.
// - Run 3 machine cycles -> phase_strobe every 27 sysclk, cyc_phase 0..7 wraps,
//   sync_ref high exactly 27 sysclk during phase 7, low otherwise.
// - POC_CYCLES=2 -> poc_out=1 until edge 432 (2*8*27) after first run edge, then 0;
//   POC_CYCLES=0 -> poc_out=0 on first edge after release.
// - Drop clk_en during M1 -> cycle completes through X3, then clk1=clk2=0, cyc_phase=7
//   held; raise clk_en -> same edge tick 0, A1, clk1=1.
// - Assert reset at M2 tick 10 -> next edge all outputs at reset values, poc_out=1;
//   release -> full POC_CYCLES recount from A1.
// - MCS4_STEP_EN, halted, 1-sysclk step -> exactly 8 clk1 and 8 clk2 pulses, sync_ref
//   once, then HALT; step during RUN -> no change.

Source files
------------

// File: rtl/mcs4_phase_gen.sv
// MCS-4 two-phase clock, machine-cycle tracker, sync and power-on clear; MCS4_STEP_EN adds single-cycle stepping.
// All outputs registered (one sysclk from tick); no backpressure, clk_en/step act only at the X3 boundary or in HALT.
module mcs4_phase_gen #(
    parameter int SYSCLK_TCY = 50,
    parameter int TCY_NS     = 1350,
    parameter int PW_NS      = 400,
    parameter int GAP12_NS   = 400,
    parameter int POC_CYCLES = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       clk_en,
`ifdef MCS4_STEP_EN
    input  logic       step,
`endif
    output logic       clk1,
    output logic       clk2,
    output logic       phase_strobe,
    output logic [2:0] cyc_phase,
    output logic       sync_ref,
    output logic       poc_out
);

    localparam int TCY = (TCY_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int PW  = (PW_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int G   = (GAP12_NS + SYSCLK_TCY - 1) / SYSCLK_TCY;
    localparam int TW  = (TCY > 1) ? $clog2(TCY) : 1;
    localparam int CW  = (POC_CYCLES > 0) ? $clog2(POC_CYCLES + 1) : 1;

    localparam logic [TW-1:0] TICK_LAST = TW'(TCY - 1);
    localparam logic [TW-1:0] C1_OFF    = TW'(PW);
    localparam logic [TW-1:0] C2_ON     = TW'(PW + G);
    localparam logic [TW-1:0] C2_OFF    = TW'(2 * PW + G);
    localparam logic [CW-1:0] POC_LAST  = CW'(POC_CYCLES);

    if (TCY < 2 * PW + G + 1) begin : g_bad_timing
        $error("mcs4_phase_gen: TCY must be at least 2*PW + G + 1 ticks");
    end

    typedef enum logic {ST_HALT, ST_RUN} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    phase_q, phase_d;
    logic [CW-1:0] poc_cnt_q, poc_cnt_d;
    logic          poc_q, poc_d;
    logic          clk1_q, clk1_d;
    logic          clk2_q, clk2_d;
    logic          strobe_q, strobe_d;
    logic          sync_q, sync_d;

    logic boundary;
    logic step_go;
    logic go;
    logic run_d;

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        phase_d   = phase_q;
        poc_cnt_d = poc_cnt_q;
        poc_d     = poc_q;
        step_go   = 1'b0;
`ifdef MCS4_STEP_EN
        step_go   = step && (state_q == ST_HALT);
`endif
        go        = clk_en || step_go;
        // HALT parks the counters on the X3 last tick, so it shares the boundary decision.
        boundary  = (tick_q == TICK_LAST) && (phase_q == 3'd7);

        if (boundary) begin
            if (go) begin
                state_d = ST_RUN;
                tick_d  = '0;
                phase_d = 3'd0;
                if (state_q == ST_RUN && poc_q) begin
                    poc_cnt_d = poc_cnt_q + CW'(1);
                end
            end else begin
                state_d = ST_HALT;
            end
        end else if (state_q == ST_RUN) begin
            if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                phase_d = phase_q + 3'd1;
            end else begin
                tick_d  = tick_q + TW'(1);
            end
        end

        if (POC_CYCLES == 0 || poc_cnt_d == POC_LAST) begin
            poc_d = 1'b0;
        end

        run_d    = (state_d == ST_RUN);
        clk1_d   = run_d && (tick_d < C1_OFF);
        clk2_d   = run_d && (tick_d >= C2_ON) && (tick_d < C2_OFF);
        strobe_d = run_d && (tick_d == '0);
        sync_d   = run_d && (phase_d == 3'd7);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_HALT;
            tick_q    <= TICK_LAST;
            phase_q   <= 3'd7;
            poc_cnt_q <= '0;
            poc_q     <= 1'b1;
            clk1_q    <= 1'b0;
            clk2_q    <= 1'b0;
            strobe_q  <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
            poc_cnt_q <= poc_cnt_d;
            poc_q     <= poc_d;
            clk1_q    <= clk1_d;
            clk2_q    <= clk2_d;
            strobe_q  <= strobe_d;
            sync_q    <= sync_d;
        end
    end

    assign clk1         = clk1_q;
    assign clk2         = clk2_q;
    assign phase_strobe = strobe_q;
    assign cyc_phase    = phase_q;
    assign sync_ref     = sync_q;
    assign poc_out      = poc_q;

endmodule

// File: tb/tb_mcs4_phase_gen.sv
// Directed bench for mcs4_phase_gen: default timing plus POC_CYCLES=2 and 0 variants sharing one stimulus.
// Outputs sampled on the falling edge; inputs changed right after it.
module tb_mcs4_phase_gen;

    logic sysclk = 1'b0;
    logic reset  = 1'b1;
    logic clk_en = 1'b0;
`ifdef MCS4_STEP_EN
    logic step   = 1'b0;
`endif

    logic       d_clk1, d_clk2, d_ps, d_sync, d_poc;
    logic [2:0] d_cyc;
    logic       p2_clk1, p2_clk2, p2_ps, p2_sync, p2_poc;
    logic [2:0] p2_cyc;
    logic       p0_clk1, p0_clk2, p0_ps, p0_sync, p0_poc;
    logic [2:0] p0_cyc;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    mcs4_phase_gen dut (
        .sysclk(sysclk), .reset(reset), .clk_en(clk_en),
`ifdef MCS4_STEP_EN
        .step(step),
`endif
        .clk1(d_clk1), .clk2(d_clk2), .phase_strobe(d_ps),
        .cyc_phase(d_cyc), .sync_ref(d_sync), .poc_out(d_poc)
    );

    mcs4_phase_gen #(.POC_CYCLES(2)) dut_p2 (
        .sysclk(sysclk), .reset(reset), .clk_en(clk_en),
`ifdef MCS4_STEP_EN
        .step(step),
`endif
        .clk1(p2_clk1), .clk2(p2_clk2), .phase_strobe(p2_ps),
        .cyc_phase(p2_cyc), .sync_ref(p2_sync), .poc_out(p2_poc)
    );

    mcs4_phase_gen #(.POC_CYCLES(0)) dut_p0 (
        .sysclk(sysclk), .reset(reset), .clk_en(clk_en),
`ifdef MCS4_STEP_EN
        .step(step),
`endif
        .clk1(p0_clk1), .clk2(p0_clk2), .phase_strobe(p0_ps),
        .cyc_phase(p0_cyc), .sync_ref(p0_sync), .poc_out(p0_poc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge sysclk);
    endtask

    // n = sysclk edges since the A1 tick-0 edge of the current run
    task automatic chk_run(input int n);
        int v;
        int ph;
        v  = n % 27;
        ph = (n / 27) % 8;
        chk("clk1", d_clk1, 32'(v < 8));
        chk("clk2", d_clk2, 32'(v >= 16 && v < 24));
        chk("phase_strobe", d_ps, 32'(v == 0));
        chk("cyc_phase", d_cyc, ph);
        chk("sync_ref", d_sync, 32'(ph == 7));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_clk1"}, d_clk1, 0);
        chk({tag, "_clk2"}, d_clk2, 0);
        chk({tag, "_strobe"}, d_ps, 0);
        chk({tag, "_cyc"}, d_cyc, 7);
        chk({tag, "_sync"}, d_sync, 0);
    endtask

    always @(negedge sysclk) begin
        if (!reset) begin
            checks++;
            assert (!(d_clk1 && d_clk2) && !(p2_clk1 && p2_clk2) && !(p0_clk1 && p0_clk2)) else begin
                errors++;
                $error("FAIL overlap: clk1=%0b clk2=%0b expected not both high", d_clk1, d_clk2);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        clk_en = 1'b0;
        repeat (5) next();
        chk_idle("reset");
        chk("reset_poc", d_poc, 1);
        chk("reset_poc0", p0_poc, 1);

        // Release and run three full machine cycles
        reset  = 1'b0;
        clk_en = 1'b1;
        for (int n = 0; n < 648; n++) begin
            next();
            chk_run(n);
            chk("poc4", d_poc, 1);
            chk("poc2", p2_poc, 32'(n < 432));
            chk("poc0", p0_poc, 0);
        end

        // Drop clk_en during M1: cycle still completes through X3
        for (int n = 648; n < 864; n++) begin
            next();
            chk_run(n);
            if (n == 648 + 3 * 27 + 5) clk_en = 1'b0;
        end
        for (int k = 0; k < 10; k++) begin
            next();
            chk_idle("halt");
        end

        // Resume, then reset at M2 tick 10
        clk_en = 1'b1;
        for (int m = 0; m <= 118; m++) begin
            next();
            chk_run(m);
        end
        reset = 1'b1;
        next();
        chk_idle("midreset");
        chk("midreset_poc", d_poc, 1);
        chk("midreset_poc2", p2_poc, 1);
        chk("midreset_poc0", p0_poc, 1);

        // Full POC recount after release
        reset = 1'b0;
        for (int n = 0; n <= 864; n++) begin
            next();
            chk_run(n);
            chk("recount_poc4", d_poc, 32'(n < 864));
            chk("recount_poc2", p2_poc, 32'(n < 432));
        end

`ifdef MCS4_STEP_EN
        begin
            int waited;
            int c1;
            int c2;
            int sy;
            logic p1;
            logic p2;
            logic ps;
            clk_en = 1'b0;
            waited = 0;
            do begin
                next();
                waited++;
            end while (!(d_cyc == 3'd7 && !d_sync) && waited < 400);
            chk("halt_reached", 32'(waited < 400), 1);
            next();
            chk_idle("pre_step");
            step = 1'b1;
            next();
            step = 1'b0;
            c1 = 0; c2 = 0; sy = 0;
            p1 = 1'b0; p2 = 1'b0; ps = 1'b0;
            for (int i = 0; i < 300; i++) begin
                if (d_clk1 && !p1) c1++;
                if (d_clk2 && !p2) c2++;
                if (d_sync && !ps) sy++;
                p1 = d_clk1; p2 = d_clk2; ps = d_sync;
                step = (i == 100);
                next();
            end
            step = 1'b0;
            chk("step_clk1_pulses", c1, 8);
            chk("step_clk2_pulses", c2, 8);
            chk("step_sync_pulses", sy, 1);
            chk_idle("post_step");
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
